// File: rtl/instr_sequencer.sv
// Instruction sequencer: issuing end of the 9-bit CPU instruction bus.
// A host fills a small program buffer while idle. On start the words
// are driven one at a time, each held for a per-class number of cycles
// (ALU class when op[1] is set, memory class otherwise). Progress is
// reported through pc/busy/done.
module instr_sequencer #(
    parameter int IW         = 9,
    parameter int AW         = 5,
    parameter int ALU_CYCLES = 2,
    parameter int MEM_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          stop,
    output logic [IW-1:0] instruction,
    output logic          instr_valid,
    output logic          issue_pulse,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    localparam int DEPTH = 2 ** AW;
    localparam int HMAX  = (ALU_CYCLES > MEM_CYCLES) ? ALU_CYCLES : MEM_CYCLES;
    localparam int CW    = (HMAX > 1) ? $clog2(HMAX) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [AW:0]   len_q;
    logic [CW-1:0] cnt;
    logic [IW-1:0] prog_buf [DEPTH];

    logic [CW-1:0] hold_max;
    logic          hold_last;
    logic          pc_last;
    logic [AW-1:0] pc_nxt;

    // Hold length follows the class of the word currently on the bus;
    // the last-word test is done in AW+1 bits so len=32 never aliases.
    always_comb begin
        hold_max  = instruction[IW-1] ? CW'(ALU_CYCLES - 1) : CW'(MEM_CYCLES - 1);
        hold_last = (cnt == hold_max);
        pc_last   = ({1'b0, pc} == (len_q - (AW+1)'(1)));
        pc_nxt    = pc + AW'(1);
    end

    // Program buffer: written only while idle, never reset.
    always_ff @(posedge clk) begin
        if (prog_we && (state == ST_IDLE) && !rst) begin
            prog_buf[prog_addr] <= prog_data;
        end
    end

    // Sequencer FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            cnt         <= '0;
            pc          <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            issue_pulse <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done        <= 1'b0;
                    issue_pulse <= 1'b0;
                    if (start) begin
                        if (prog_len != '0) begin
                            state       <= ST_RUN;
                            len_q       <= prog_len;
                            pc          <= '0;
                            cnt         <= '0;
                            instruction <= prog_buf[0];
                            instr_valid <= 1'b1;
                            issue_pulse <= 1'b1;
                            busy        <= 1'b1;
                        end else begin
                            // Empty program: report completion without issuing.
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // Abort: pc keeps the index that was in flight.
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        instruction <= '0;
                        instr_valid <= 1'b0;
                        issue_pulse <= 1'b0;
                        busy        <= 1'b0;
                    end else if (hold_last) begin
                        cnt <= '0;
                        if (pc_last) begin
                            state       <= ST_DONE;
                            instruction <= '0;
                            instr_valid <= 1'b0;
                            issue_pulse <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            pc          <= pc_nxt;
                            instruction <= prog_buf[pc_nxt];
                            issue_pulse <= 1'b1;
                        end
                    end else begin
                        cnt         <= cnt + CW'(1);
                        issue_pulse <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_valid <= 1'b0;
                    issue_pulse <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, mixed-class program,
// full-length program, abort, write-while-running, empty program.
module tb_instr_sequencer;

    localparam int IW = 9;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          stop;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic          issue_pulse;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [IW-1:0] mem [32];

    instr_sequencer #(.IW(IW), .AW(AW), .ALU_CYCLES(2), .MEM_CYCLES(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .stop        (stop),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .issue_pulse (issue_pulse),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed compare of all outputs: {instruction, valid, issue, pc, busy, done}.
    task automatic check_all(input string tag, input logic [IW-1:0] e_instr, input logic e_v,
                             input logic e_iss, input logic [AW-1:0] e_pc,
                             input logic e_busy, input logic e_done);
        check(tag, {14'd0, instruction, instr_valid, issue_pulse, pc, busy, done},
                   {14'd0, e_instr, e_v, e_iss, e_pc, e_busy, e_done});
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [IW-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic run(input logic [AW:0] len);
        prog_len = len;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; start = 1'b0; stop = 1'b0;
        step();
        step();
        check_all("reset", 9'h000, 0, 0, 5'd0, 0, 0);
        rst = 1'b0;

        // Mixed program: memory word then ALU word.
        wr(5'd0, 9'h0A5);
        wr(5'd1, 9'h1C3);
        run(6'd2);
        check_all("t2_w0", 9'h0A5, 1, 1, 5'd0, 1, 0);
        step();
        check_all("t2_w1a", 9'h1C3, 1, 1, 5'd1, 1, 0);
        step();
        check_all("t2_w1b", 9'h1C3, 1, 0, 5'd1, 1, 0);
        step();
        check_all("t2_done", 9'h000, 0, 0, 5'd1, 0, 1);
        step();
        check("t2_done_clr", {31'd0, done}, 32'd0);

        // Fill all 32 entries with memory-class words.
        for (int i = 0; i < 32; i++) begin
            mem[i] = 9'(9'h040 + 3 * i);
            wr(5'(i), mem[i]);
        end

        // Reset mid-run at pc=3, then restart from buf[0].
        run(6'd10);
        step(); step(); step();
        check("t1_pc3", {27'd0, pc}, 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all("t1_rst", 9'h000, 0, 0, 5'd0, 0, 0);
        run(6'd1);
        check_all("t1_restart", mem[0], 1, 1, 5'd0, 1, 0);
        step();
        check_all("t1_done", 9'h000, 0, 0, 5'd0, 0, 1);
        step();

        // Full-length program: one word per cycle, no wrap.
        run(6'd32);
        for (int i = 0; i < 32; i++) begin
            check_all($sformatf("t3_pc%0d", i), mem[i], 1, 1, 5'(i), 1, 0);
            step();
        end
        check_all("t3_done", 9'h000, 0, 0, 5'd31, 0, 1);
        step();
        check_all("t3_idle", 9'h000, 0, 0, 5'd31, 0, 0);

        // Abort on the second hold cycle of an ALU word at pc=2.
        wr(5'd2, 9'h1F0);
        mem[2] = 9'h1F0;
        run(6'd5);
        step();
        step();
        check_all("t4_alu_c1", 9'h1F0, 1, 1, 5'd2, 1, 0);
        step();
        check_all("t4_alu_c2", 9'h1F0, 1, 0, 5'd2, 1, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4_valid", {31'd0, instr_valid}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_pc", {27'd0, pc}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_no_done", {26'd0, done, pc}, {26'd0, 1'b0, 5'd2});
        end

        // Write during RUN to pc+1 must be ignored.
        run(6'd2);
        check_all("t5_w0", mem[0], 1, 1, 5'd0, 1, 0);
        prog_we = 1'b1; prog_addr = 5'd1; prog_data = 9'h155;
        step();
        prog_we = 1'b0;
        check_all("t5_w1", mem[1], 1, 1, 5'd1, 1, 0);
        step();
        check_all("t5_done", 9'h000, 0, 0, 5'd1, 0, 1);
        step();
        run(6'd2);
        step();
        check_all("t5_buf_kept", mem[1], 1, 1, 5'd1, 1, 0);
        step();
        step();

        // Empty program: a single done pulse, nothing issued.
        run(6'd0);
        check("t6_done", {29'd0, done, instr_valid, busy}, {29'd0, 3'b100});
        check("t6_issue", {31'd0, issue_pulse}, 32'd0);
        step();
        check("t6_done_clr", {30'd0, done, instr_valid}, 32'd0);
        step();
        check("t6_once", {30'd0, done, instr_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
